cond_exec_pipe: RTL and testbench

Parametrised, pipelined successor to the control path's conditional-logic stage. It sits between decode and the EX/MEM boundary of the pipelined core. It holds the architectural NZCV flag register and evaluates each instruction's condition field against it. It then gates PCSrc/RegWrite/MemWrite and registers the result into the next stage, with stall, flush, flag save/restore for exception entry/return, and a saturating taken-branch counter.

---
 rtl/cond_pkg.sv | 50 +++++
 rtl/cond_exec_pipe_if.sv | 42 ++++
 rtl/cond_check.sv | 60 ++++++
 rtl/cond_exec_pipe.sv | 102 ++++++++++
 tb/tb_cond_exec_pipe.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/cond_pkg.sv
// Shared types and constants for the conditional-execution stage.
package cond_pkg;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned N_IDX  = 3;
    localparam int unsigned Z_IDX  = 2;
    localparam int unsigned C_IDX  = 1;
    localparam int unsigned V_IDX  = 0;

    localparam logic [1:0] OP_BRANCH = 2'b11;

    typedef enum logic [2:0] {
        COND3_AL = 3'b000,
        COND3_EQ = 3'b001,
        COND3_NE = 3'b010,
        COND3_GT = 3'b011,
        COND3_GE = 3'b100,
        COND3_LT = 3'b101,
        COND3_LE = 3'b110,
        COND3_NV = 3'b111
    } cond3_e;

    typedef enum logic [3:0] {
        COND4_EQ = 4'b0000,
        COND4_NE = 4'b0001,
        COND4_CS = 4'b0010,
        COND4_CC = 4'b0011,
        COND4_MI = 4'b0100,
        COND4_PL = 4'b0101,
        COND4_VS = 4'b0110,
        COND4_VC = 4'b0111,
        COND4_HI = 4'b1000,
        COND4_LS = 4'b1001,
        COND4_GE = 4'b1010,
        COND4_LT = 4'b1011,
        COND4_GT = 4'b1100,
        COND4_LE = 4'b1101,
        COND4_AL = 4'b1110,
        COND4_NV = 4'b1111
    } cond4_e;

    typedef struct packed {
        logic valid;
        logic pc_src;
        logic reg_write;
        logic mem_write;
        logic cond_ex;
    } stage_out_t;

endpackage

// File: rtl/cond_exec_pipe_if.sv
// Decode-side controls in, gated EX/MEM controls and flag state out.
interface cond_exec_pipe_if #(
    parameter int unsigned COND_W = 3,
    parameter int unsigned CNT_W  = 16
);
    logic              in_valid;
    logic              stall;
    logic              flush;
    logic [1:0]        op;
    logic [COND_W-1:0] cond;
    logic [3:0]        alu_flags;
    logic [1:0]        flag_w;
    logic              pcs;
    logic              reg_w;
    logic              mem_w;
    logic              no_write;
    logic              save_flags;
    logic              restore_flags;

    logic              out_valid;
    logic              pc_src;
    logic              reg_write;
    logic              mem_write;
    logic              cond_ex;
    logic [3:0]        flags;
    logic [3:0]        shadow_flags;
    logic [CNT_W-1:0]  taken_count;

    modport master (
        output in_valid, stall, flush, op, cond, alu_flags, flag_w,
               pcs, reg_w, mem_w, no_write, save_flags, restore_flags,
        input  out_valid, pc_src, reg_write, mem_write, cond_ex,
               flags, shadow_flags, taken_count
    );

    modport slave (
        input  in_valid, stall, flush, op, cond, alu_flags, flag_w,
               pcs, reg_w, mem_w, no_write, save_flags, restore_flags,
        output out_valid, pc_src, reg_write, mem_write, cond_ex,
               flags, shadow_flags, taken_count
    );
endinterface

// File: rtl/cond_check.sv
// Combinational condition-code evaluator against an NZCV flag vector.
module cond_check
    import cond_pkg::*;
#(
    parameter int unsigned COND_W = 3
) (
    input  logic [COND_W-1:0] cond,
    input  logic [3:0]        flags,
    output logic              cond_ex
);

    logic n, z, c, v;
    assign n = flags[N_IDX];
    assign z = flags[Z_IDX];
    assign c = flags[C_IDX];
    assign v = flags[V_IDX];

    if (COND_W == 3) begin : g_w3
        cond3_e code;
        assign code = cond3_e'(cond);
        always_comb begin
            cond_ex = 1'b0;
            case (code)
                COND3_AL: cond_ex = 1'b1;
                COND3_EQ: cond_ex = z;
                COND3_NE: cond_ex = ~z;
                COND3_GT: cond_ex = ~z & (n == v);
                COND3_GE: cond_ex = (n == v);
                COND3_LT: cond_ex = (n != v);
                COND3_LE: cond_ex = z | (n != v);
                default:  cond_ex = 1'b0;
            endcase
        end
    end else begin : g_w4
        cond4_e code;
        assign code = cond4_e'(cond);
        always_comb begin
            cond_ex = 1'b0;
            case (code)
                COND4_EQ: cond_ex = z;
                COND4_NE: cond_ex = ~z;
                COND4_CS: cond_ex = c;
                COND4_CC: cond_ex = ~c;
                COND4_MI: cond_ex = n;
                COND4_PL: cond_ex = ~n;
                COND4_VS: cond_ex = v;
                COND4_VC: cond_ex = ~v;
                COND4_HI: cond_ex = c & ~z;
                COND4_LS: cond_ex = ~c | z;
                COND4_GE: cond_ex = (n == v);
                COND4_LT: cond_ex = (n != v);
                COND4_GT: cond_ex = ~z & (n == v);
                COND4_LE: cond_ex = z | (n != v);
                COND4_AL: cond_ex = 1'b1;
                default:  cond_ex = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/cond_exec_pipe.sv
// Conditional-execution stage: NZCV register, shadow copy, gated control
// pipeline register and saturating taken-branch counter.
module cond_exec_pipe
    import cond_pkg::*;
#(
    parameter int unsigned COND_W = 3,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    cond_exec_pipe_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    stage_out_t       out_q, out_d;
    logic [3:0]       flags_q, flags_d;
    logic [3:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept_c;
    logic cond_ex_c;

    // Condition is resolved against the registered flags so a flag-setting
    // instruction feeds the very next one without a bubble.
    cond_check #(.COND_W(COND_W)) u_cond_check (
        .cond    (bus.cond),
        .flags   (flags_q),
        .cond_ex (cond_ex_c)
    );

    assign accept_c = bus.in_valid & ~bus.stall & ~bus.flush;

    always_comb begin
        out_d    = out_q;
        flags_d  = flags_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;

        if (bus.flush) begin
            out_d = '0;
        end else if (!bus.stall) begin
            if (accept_c) begin
                out_d.valid     = 1'b1;
                out_d.pc_src    = bus.pcs & cond_ex_c;
                out_d.reg_write = bus.reg_w & cond_ex_c & ~bus.no_write;
                out_d.mem_write = bus.mem_w & cond_ex_c;
                out_d.cond_ex   = cond_ex_c;
            end else begin
                out_d = '0;
            end
        end

        if (accept_c && cond_ex_c) begin
            if (bus.flag_w[1]) begin
                flags_d[N_IDX] = bus.alu_flags[N_IDX];
                flags_d[Z_IDX] = bus.alu_flags[Z_IDX];
            end
            if (bus.flag_w[0]) begin
                flags_d[C_IDX] = bus.alu_flags[C_IDX];
                flags_d[V_IDX] = bus.alu_flags[V_IDX];
            end
        end

        // Save/restore use pre-edge values, so both together swap.
        if (bus.save_flags) begin
            shadow_d = flags_q;
        end
        if (bus.restore_flags) begin
            flags_d = shadow_q;
        end

        if (accept_c && (bus.op == OP_BRANCH) && bus.pcs && cond_ex_c
            && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q    <= '0;
            flags_q  <= '0;
            shadow_q <= '0;
            cnt_q    <= '0;
        end else begin
            out_q    <= out_d;
            flags_q  <= flags_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.out_valid    = out_q.valid;
    assign bus.pc_src       = out_q.pc_src;
    assign bus.reg_write    = out_q.reg_write;
    assign bus.mem_write    = out_q.mem_write;
    assign bus.cond_ex      = out_q.cond_ex;
    assign bus.flags        = flags_q;
    assign bus.shadow_flags = shadow_q;
    assign bus.taken_count  = cnt_q;

endmodule

// File: tb/tb_cond_exec_pipe.sv
// Bench for cond_exec_pipe: three configurations driven in lockstep against a
// flag/condition reference model.
module tb_cond_exec_pipe;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       in_valid, stall, flush, pcs, reg_w, mem_w, no_write, save_f, restore_f;
    logic [1:0] op, flag_w;
    logic [2:0] cond3;
    logic [3:0] cond4, alu_flags;

    cond_exec_pipe_if #(.COND_W(3), .CNT_W(16)) if0 ();
    cond_exec_pipe_if #(.COND_W(3), .CNT_W(2))  if1 ();
    cond_exec_pipe_if #(.COND_W(4), .CNT_W(2))  if2 ();

    cond_exec_pipe #(.COND_W(3), .CNT_W(16)) u0 (.clk(clk), .reset(reset), .bus(if0));
    cond_exec_pipe #(.COND_W(3), .CNT_W(2))  u1 (.clk(clk), .reset(reset), .bus(if1));
    cond_exec_pipe #(.COND_W(4), .CNT_W(2))  u2 (.clk(clk), .reset(reset), .bus(if2));

    assign if0.in_valid = in_valid; assign if1.in_valid = in_valid; assign if2.in_valid = in_valid;
    assign if0.stall = stall;       assign if1.stall = stall;       assign if2.stall = stall;
    assign if0.flush = flush;       assign if1.flush = flush;       assign if2.flush = flush;
    assign if0.op = op;             assign if1.op = op;             assign if2.op = op;
    assign if0.cond = cond3;        assign if1.cond = cond3;        assign if2.cond = cond4;
    assign if0.alu_flags = alu_flags; assign if1.alu_flags = alu_flags; assign if2.alu_flags = alu_flags;
    assign if0.flag_w = flag_w;     assign if1.flag_w = flag_w;     assign if2.flag_w = flag_w;
    assign if0.pcs = pcs;           assign if1.pcs = pcs;           assign if2.pcs = pcs;
    assign if0.reg_w = reg_w;       assign if1.reg_w = reg_w;       assign if2.reg_w = reg_w;
    assign if0.mem_w = mem_w;       assign if1.mem_w = mem_w;       assign if2.mem_w = mem_w;
    assign if0.no_write = no_write; assign if1.no_write = no_write; assign if2.no_write = no_write;
    assign if0.save_flags = save_f; assign if1.save_flags = save_f; assign if2.save_flags = save_f;
    assign if0.restore_flags = restore_f; assign if1.restore_flags = restore_f; assign if2.restore_flags = restore_f;

    logic [31:0] obs [3];
    assign obs[0] = {3'b0, if0.out_valid, if0.pc_src, if0.reg_write, if0.mem_write, if0.cond_ex,
                     if0.flags, if0.shadow_flags, 16'(if0.taken_count)};
    assign obs[1] = {3'b0, if1.out_valid, if1.pc_src, if1.reg_write, if1.mem_write, if1.cond_ex,
                     if1.flags, if1.shadow_flags, 16'(if1.taken_count)};
    assign obs[2] = {3'b0, if2.out_valid, if2.pc_src, if2.reg_write, if2.mem_write, if2.cond_ex,
                     if2.flags, if2.shadow_flags, 16'(if2.taken_count)};

    // Reference state per configuration; out = {valid, pc_src, reg_write, mem_write, cond_ex}.
    logic [4:0] m_out    [3];
    logic [3:0] m_flags  [3];
    logic [3:0] m_shadow [3];
    int         m_cnt    [3];
    int         cmax     [3] = '{65535, 3, 3};

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vec++;
        if (observed !== expected) begin
            n_err++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic eval_cond(input int w, input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        if (w == 3) begin
            case (c[2:0])
                3'd0: return 1'b1;
                3'd1: return z;
                3'd2: return !z;
                3'd3: return !z && (n == v);
                3'd4: return n == v;
                3'd5: return n != v;
                3'd6: return z || (n != v);
                default: return 1'b0;
            endcase
        end
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            logic       ce, acc;
            logic [3:0] c, nf, ns;
            if (reset) begin
                m_out[i] = '0; m_flags[i] = '0; m_shadow[i] = '0; m_cnt[i] = 0;
                continue;
            end
            c   = (i == 2) ? cond4 : {1'b0, cond3};
            ce  = eval_cond((i == 2) ? 4 : 3, c, m_flags[i]);
            acc = in_valid && !stall && !flush;
            if (flush)       m_out[i] = '0;
            else if (!stall) m_out[i] = acc ? {1'b1, pcs & ce, reg_w & ce & !no_write, mem_w & ce, ce} : 5'b0;
            nf = m_flags[i];
            if (acc && ce) begin
                if (flag_w[1]) nf[3:2] = alu_flags[3:2];
                if (flag_w[0]) nf[1:0] = alu_flags[1:0];
            end
            ns = save_f ? m_flags[i] : m_shadow[i];
            if (restore_f) nf = m_shadow[i];
            if (acc && op == 2'b11 && pcs && ce && m_cnt[i] < cmax[i]) m_cnt[i]++;
            m_flags[i]  = nf;
            m_shadow[i] = ns;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        cyc++;
        for (int i = 0; i < 3; i++)
            chk($sformatf("cyc%0d_u%0d", cyc, i), obs[i],
                {3'b0, m_out[i], m_flags[i], m_shadow[i], 16'(m_cnt[i])});
    endtask

    task automatic idle();
        in_valid = 0; stall = 0; flush = 0; op = 2'b00; cond3 = 3'b000; cond4 = 4'b1110;
        alu_flags = 4'b0000; flag_w = 2'b00; pcs = 0; reg_w = 0; mem_w = 0; no_write = 0;
        save_f = 0; restore_f = 0;
    endtask

    task automatic cmp(input logic [3:0] f);
        idle(); in_valid = 1; flag_w = 2'b11; alu_flags = f;
    endtask

    task automatic branch(input logic [2:0] c3, input logic [3:0] c4);
        idle(); in_valid = 1; op = 2'b11; pcs = 1; cond3 = c3; cond4 = c4;
    endtask

    initial begin
        idle();
        reset = 1;
        step(); step();
        chk("rst_state", obs[0], 32'h0);
        reset = 0;

        // CMP then BGT
        cmp(4'b0010); step();
        chk("cmp_flags", 32'(if0.flags), 32'h2);
        branch(3'b011, 4'b1100); step();
        chk("bgt_pc_src", 32'(if0.pc_src), 32'h1);
        chk("bgt_count", 32'(if0.taken_count), 32'h1);

        // CMP then BLT: not taken
        cmp(4'b0010); step();
        branch(3'b101, 4'b1011); step();
        chk("blt_pc_src", 32'(if0.pc_src), 32'h0);
        chk("blt_count", 32'(if0.taken_count), 32'h1);

        // ADD EQ with Z clear
        idle(); in_valid = 1; cond3 = 3'b001; cond4 = 4'b0000; reg_w = 1; flag_w = 2'b11; alu_flags = 4'b1111;
        step();
        chk("addeq_regw", 32'(if0.reg_write), 32'h0);
        chk("addeq_flags", 32'(if0.flags), 32'h2);

        // Stall two cycles on a taken branch, then release
        branch(3'b011, 4'b1100); stall = 1; step(); step();
        chk("stall_count", 32'(if0.taken_count), 32'h1);
        stall = 0; step();
        chk("release_count", 32'(if0.taken_count), 32'h2);
        stall = 1; flush = 1; step();
        chk("flush_stall_out", {27'b0, if0.out_valid, if0.pc_src, if0.reg_write, if0.mem_write, if0.cond_ex}, 32'h0);

        // Save / swap
        cmp(4'b1000); step();
        idle(); save_f = 1; step();
        cmp(4'b0100); step();
        idle(); save_f = 1; restore_f = 1; step();
        chk("swap_flags", 32'(if0.flags), 32'h8);
        chk("swap_shadow", 32'(if0.shadow_flags), 32'h4);

        // Saturation on CNT_W=2 configurations
        for (int k = 0; k < 4; k++) begin
            branch(3'b000, 4'b1110); step();
        end
        chk("sat_w3", 32'(if1.taken_count), 32'h3);
        chk("sat_w4", 32'(if2.taken_count), 32'h3);
        branch(3'b111, 4'b1111); step();
        chk("nv_pc_src", 32'(if2.pc_src), 32'h0);

        // Randomized traffic with occasional mid-run reset
        for (int k = 0; k < 600; k++) begin
            reset     = ($urandom_range(0, 63) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            stall     = ($urandom_range(0, 4) == 0);
            flush     = ($urandom_range(0, 7) == 0);
            op        = 2'($urandom);
            cond3     = 3'($urandom);
            cond4     = 4'($urandom);
            alu_flags = 4'($urandom);
            flag_w    = 2'($urandom);
            pcs       = 1'($urandom);
            reg_w     = 1'($urandom);
            mem_w     = 1'($urandom);
            no_write  = ($urandom_range(0, 3) == 0);
            save_f    = ($urandom_range(0, 5) == 0);
            restore_f = ($urandom_range(0, 5) == 0);
            step();
        end
        reset = 0;
        idle();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
